// File: rtl/rsa_mod_exp.sv
// rsa_mod_exp: modular exponentiation engine, result = base^exponent mod modulus.
// Uses left-to-right binary square-and-multiply over the KEY_W-bit key.
// Each modular product runs on a bit-serial interleaved shift-add-reduce
// multiplier that consumes one multiplier bit per clock, MSB first.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous, active-high reset (aborts any operation, no done)
//   start    - one-cycle request, accepted only while idle
//   base     - message/ciphertext, must be < modulus
//   exponent - key exponent, KEY_W bits
//   modulus  - RSA modulus n, must be >= 2
//   result   - base^exponent mod modulus (0 on operand error), held until next start
//   done     - one-cycle completion pulse
//   busy     - high whenever the engine is not idle
//   err      - operand violation flag, held until next start
//
// Build option: define RSA_MOD_EXP_CONST_TIME_EN to run a multiply after every
// square regardless of the key bit (product kept only for 1 bits), making the
// latency independent of the key value.
module rsa_mod_exp #(
  parameter int W     = 8,
  parameter int KEY_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [KEY_W-1:0] exponent,
  input  logic [W-1:0]     modulus,
  output logic [W-1:0]     result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [W-1:0]     base_r;
  logic [KEY_W-1:0] exp_r;
  logic [W-1:0]     mod_r;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     prod_r;
  logic [CW-1:0]    bit_r;
  logic [IW-1:0]    idx_r;

  logic             mul_b_s;
  logic [W-1:0]     step_s;
  logic             key_bit_s;
  logic             mul_last_s;
  logic             acc_wr_s;
  logic [W-1:0]     acc_next_s;
  logic             bad_op_s;

  // One interleaved step: P = (2P mod n + (bit ? a : 0)) mod n.
  // With P < n and a < n every intermediate fits in W+1 bits.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] p,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] n,
                                           input logic         b_bit);
    logic [W:0] t;
    logic [W:0] u;
    t = {p, 1'b0};
    if (t >= {1'b0, n}) begin
      t = t - {1'b0, n};
    end else begin
      t = t;
    end
    u = t + (b_bit ? {1'b0, a} : {(W+1){1'b0}});
    if (u >= {1'b0, n}) begin
      u = u - {1'b0, n};
    end else begin
      u = u;
    end
    return u[W-1:0];
  endfunction

  // Multiplier datapath: select the multiplier bit and compute the next partial product.
  always_comb begin
    mul_b_s = 1'b0;
    case (state_r)
      SQR:     mul_b_s = acc_r[bit_r];
      MUL:     mul_b_s = base_r[bit_r];
      default: mul_b_s = 1'b0;
    endcase
    step_s     = mm_step(prod_r, acc_r, mod_r, mul_b_s);
    key_bit_s  = exp_r[idx_r];
    mul_last_s = (bit_r == '0);
`ifdef RSA_MOD_EXP_CONST_TIME_EN
    // Dummy multiplies for zero key bits are computed but discarded.
    acc_wr_s   = (state_r == SQR) || key_bit_s;
`else
    acc_wr_s   = 1'b1;
`endif
    acc_next_s = acc_wr_s ? step_s : acc_r;
    // modulus < 2 means every bit above bit 0 is clear.
    bad_op_s   = (mod_r[W-1:1] == '0) || (base_r >= mod_r);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      base_r  <= '0;
      exp_r   <= '0;
      mod_r   <= '0;
      acc_r   <= '0;
      prod_r  <= '0;
      bit_r   <= '0;
      idx_r   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r  <= base;
            exp_r   <= exponent;
            mod_r   <= modulus;
            busy    <= 1'b1;
            state_r <= LOAD;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (bad_op_s) begin
            err     <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            err     <= 1'b0;
            acc_r   <= {{(W-1){1'b0}}, 1'b1};
            prod_r  <= '0;
            bit_r   <= CW'(W - 1);
            idx_r   <= IW'(KEY_W - 1);
            state_r <= SQR;
          end
        end
        SQR, MUL: begin
          if (mul_last_s) begin
            acc_r  <= acc_next_s;
            prod_r <= '0;
            bit_r  <= CW'(W - 1);
`ifdef RSA_MOD_EXP_CONST_TIME_EN
            if (state_r == SQR) begin
`else
            if ((state_r == SQR) && key_bit_s) begin
`endif
              state_r <= MUL;
            end else if (idx_r == '0) begin
              // result is taken from the freshly finished product.
              result  <= acc_next_s;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              idx_r   <= idx_r - IW'(1);
              state_r <= SQR;
            end
          end else begin
            prod_r  <= step_s;
            bit_r   <= bit_r - CW'(1);
            state_r <= state_r;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mod_exp.sv
// Testbench for rsa_mod_exp: directed and randomized operations checked
// against a plain-arithmetic reference (repeated multiplication mod n).
module tb_rsa_mod_exp;

  localparam int W      = 8;
  localparam int KEY_W  = 6;
  localparam int BUDGET = 300;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     base;
  logic [KEY_W-1:0] exponent;
  logic [W-1:0]     modulus;
  logic [W-1:0]     result;
  logic             done;
  logic             busy;
  logic             err;

  int n_checks;
  int n_fails;

  rsa_mod_exp #(.W(W), .KEY_W(KEY_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: multiply e times, reducing mod m each time.
  function automatic int ref_pow(input int b, input int e, input int m);
    longint r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return int'(r % m);
  endfunction

  function automatic int ref_latency(input int b, input int e, input int m);
    int ops;
    if (m < 2 || b >= m) return 1;
`ifdef RSA_MOD_EXP_CONST_TIME_EN
    ops = 2 * KEY_W;
`else
    ops = KEY_W + $countones(e[KEY_W-1:0]);
`endif
    return 1 + W * ops;
  endfunction

  // Run one operation; if intrude > 0, pulse start with other operands at that cycle.
  task automatic run_op(input string tag, input int b, input int e, input int m, input int intrude);
    int   lat_exp, res_exp, err_exp, got;
    logic busy_ok;
    err_exp = (m < 2 || b >= m) ? 1 : 0;
    res_exp = err_exp ? 0 : ref_pow(b, e, m);
    lat_exp = ref_latency(b, e, m);
    got     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    base = b[W-1:0]; exponent = e[KEY_W-1:0]; modulus = m[W-1:0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after acceptance; they must have no effect.
    base = W'($urandom); exponent = KEY_W'($urandom); modulus = W'($urandom);
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got = k;
        break;
      end
      if (intrude > 0 && k == intrude) begin
        base = 8'd3; exponent = 6'd5; modulus = 8'd17; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, got, lat_exp);
    check({tag, " result"}, result, res_exp);
    check({tag, " err"}, err, err_exp);
    check({tag, " busy"}, busy_ok, 1);
    @(negedge clk);
    check({tag, " done_low"}, done, 0);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " result_hold"}, result, res_exp);
  endtask

  initial begin
    int   m, b, e;
    logic seen_done;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset result", result, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);

    run_op("basic", 7, 13, 11, 0);
    run_op("rsa_enc", 88, 7, 187, 0);
    run_op("rsa_dec", 11, 23, 187, 0);
    run_op("exp_zero", 5, 0, 13, 0);
    run_op("base_ge_mod", 200, 7, 187, 0);
    run_op("mod_one", 0, 3, 1, 0);
    run_op("mod_zero", 0, 9, 0, 0);
    run_op("mod_two", 1, 45, 2, 0);
    run_op("max_exp", 254, 63, 255, 0);
    run_op("start_busy", 7, 13, 11, 10);

    // Mid-operation reset: abort with no done pulse.
    @(negedge clk);
    base = 8'd88; exponent = 6'd7; modulus = 8'd187; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort err", err, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort no_done", seen_done, 0);
    run_op("after_abort", 88, 7, 187, 0);

    // Randomized valid and occasional invalid operands.
    for (int n = 0; n < 12; n++) begin
      m = int'($urandom_range(2, 255));
      b = (n % 4 == 3) ? int'($urandom_range(m, 255)) : int'($urandom_range(0, m - 1));
      e = int'($urandom_range(0, 63));
      run_op("random", b, e, m, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rsa_mod_exp.md
Name: rsa_mod_exp

Overview:
- Modular exponentiation engine for the RSA datapath: computes result = base^exponent mod modulus.
- Left-to-right binary square-and-multiply over the KEY_W-bit key.
- Each modular product uses a bit-serial interleaved shift-add-reduce multiplier, one bit per clock.
- Sits downstream of the key-bit counter/sequencer and consumes the key it walks. Output feeds the encrypt/decrypt result register.

Parameters:
- W, 8, operand width of base, modulus and result.
- KEY_W, 6, exponent (key) width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only in IDLE
- base  input  W  message/ciphertext; must be < modulus
- exponent  input  KEY_W  public or private key exponent
- modulus  input  W  RSA modulus n; must be >= 2
- result  output  W  base^exponent mod modulus
- done  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE
- err  output  1  operand violation flag

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, result=0, done=0, busy=0, err=0, all internal registers cleared. Reset mid-operation aborts immediately with no done pulse.
- States are IDLE, LOAD, SQR, MUL, DONE.
- IDLE:
  - On start=1, capture base, exponent and modulus into internal registers, then go to LOAD.
  - Inputs are not sampled again until the next accepted start.
- LOAD (1 cycle):
  - If modulus<2 or base>=modulus: err=1, result=0, go to DONE.
  - Otherwise: err=0, acc=1, bit index i=KEY_W-1, go to SQR.
- Modular multiply P=a*b mod n (W cycles, b scanned MSB to LSB):
  - P starts at 0.
  - Each cycle: t=2P; if t>=n then t=t-n; u=t+(b[j]?a:0); if u>=n then u=u-n; P=u.
  - Intermediate values are W+1 bits wide; invariant P<n; no overflow.
- SQR: acc=acc*acc mod n (W cycles). Then:
  - if exponent[i]=1, go to MUL;
  - else if i=0, go to DONE;
  - else i=i-1 and go to SQR.
- MUL: acc=acc*base mod n (W cycles). Then go to DONE if i=0, else i=i-1 and go to SQR.
- DONE (1 cycle):
  - done=1; result=acc, or 0 if err.
  - Go to IDLE unconditionally.
  - result and err hold until the next accepted start or reset.
- Latency: ops = KEY_W + popcount(exponent). done is high in the cycle beginning 1+W*ops clock edges after the edge that sampled start.
- Operand error case: ops=0, so done rises 1 edge after the start edge.
- start while busy (including DONE): ignored; no re-capture.
- exponent=0: only squarings of 1 are performed; result=1.
- modulus=2: valid; result = base^e mod 2.
- Changing the inputs after start has been accepted has no effect.

Optional Feature:
- Macro: RSA_MOD_EXP_CONST_TIME_EN
- Defined:
  - MUL is executed after every SQR regardless of exponent[i].
  - The product is written to acc only when exponent[i]=1; otherwise it is discarded.
  - ops = 2*KEY_W, so latency is independent of the key (timing side-channel hardening).
  - Results are identical to the undefined build.
- Undefined: MUL is skipped for zero key bits, as specified above.

Test Plan (W=8, KEY_W=6):
- base=7, exponent=13, modulus=11, start pulse -> result=2, err=0, done 73 edges after start (97 with CONST_TIME_EN), busy high throughout.
- Toy RSA, modulus=187: base=88, exponent=7 -> result=11 (done at 1+8*9=73). Then base=11, exponent=23 -> result=88 (done at 81; both 97 with CONST_TIME_EN).
- base=5, exponent=0, modulus=13 -> result=1, done at 49 (97 with CONST_TIME_EN).
- base=200, modulus=187 (also modulus=1) -> err=1, result=0, done 1 edge after start, busy returns low the next cycle.
- Pulse start again 10 cycles into an operation with different operands -> ignored; original result and latency unchanged.
- Assert rst for 1 cycle at cycle 30 of an operation -> busy=0, done never pulses, result=0. A new start afterwards completes normally with the correct result.
